lsu_bus_master: RTL
===================

// Module: lsu_bus_master
// PURPOSE
//  Load/store initiator between the EX stage and a handshaked data-memory bus.
//  Takes one lb/lbu/lh/lhu/lw/sb/sh/sw request, checks alignment, and drives word-aligned bus cycles with byte enables.
//  Returns the lane-extracted, sign/zero-extended load result to WB and stalls the pipeline while the bus is busy.
//  Little-endian throughout: byte lane n = bits [8n+7:8n] and is selected by addr[1:0]==n.
// PARAMETERS
//  TIMEOUT   255  max cycles in REQ without bus_ack before abort (>=1; counter width = $clog2(TIMEOUT+1))
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   synchronous reset, active-high
//  ex_valid     in   1   request present this cycle
//  ex_mem_read  in   1   load
//  ex_mem_write in   1   store
//  ex_mem_sel   in   2   00 none, 01 byte, 10 half, 11 word
//  ex_unsigned  in   1   zero-extend load (lbu/lhu); ignored for word/stores
//  ex_addr      in   32  byte address
//  ex_wdata     in   32  store data, right-justified
//  stall        out  1   freeze IF..EX
//  wb_valid     out  1   1-cycle pulse, wb_rdata valid
//  wb_rdata     out  32  extended load data
//  addr_err     out  1   1-cycle pulse: misaligned or read&write both set
//  bus_err      out  1   1-cycle pulse: timeout abort
//  bus_req      out  1   bus cycle request
//  bus_we       out  1   1 = write
//  bus_addr     out  32  {addr[31:2],2'b00}
//  bus_be       out  4   byte enables
//  bus_wdata    out  32  lane-replicated store data
//  bus_ack      in   1   responder completes cycle (sampled while bus_req=1)
//  bus_rdata    in   32  read data, valid with bus_ack
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0; every output 0.
//  - FSM IDLE -> REQ -> DONE -> IDLE. REQ -> DONE on bus_ack or timeout.
//  - Accept (IDLE only): ex_valid & (read^write) & sel!=00 & aligned. Half needs addr[0]==0, word addr[1:0]==0.
//  - Reject: misaligned or read&write both set -> addr_err=1 that cycle (combinational), no bus cycle, stall 0.
//  - ex_valid with sel==00 or neither read nor write: no-op, no error.
//  - stall = accept | (state!=IDLE && state!=DONE). Accept cycle T: stall 1. Request registered at T.
//  - REQ from T+1: bus_req=1; addr/we/be/wdata held stable until ack is sampled. ex_* ignored while busy.
//  - bus_be: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111. Reads drive the same be.
//  - bus_wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
//  - Read extract: bus_rdata >> (8*a[1:0]); low 8/16 bits sign-extended, zero-extended if ex_unsigned. Captured on ack.
//  - DONE (1 cycle): bus_req 0, stall 0; wb_valid=1 for loads only; store completion is silent.
//  - Min latency: ack at T+1 -> wb_valid at T+2. Pipeline may present the next request in DONE; accept is legal there
//    only from IDLE, so DONE -> IDLE, then accept next cycle.
//  - Timeout: counter increments each REQ cycle without ack. At TIMEOUT: bus_req drops, bus_err pulses in DONE, wb_valid 0.
//  - Ack on the same cycle the count reaches TIMEOUT: ack wins, no bus_err.
//  - bus_ack outside REQ: ignored.
//  - rst mid-transaction: bus_req drops the next edge and no wb_valid/errors are produced. The responder must tolerate an abandoned cycle.
// STRUCTURE
//  - Shared package mem_pkg: MEM_SEL_{NONE,BYTE,HALF,WORD} constants, lsu_state_t {IDLE,REQ,DONE}.
//  - One combinational sub-module lsu_lane_align: (sel, a[1:0], unsigned, wdata, rdata) -> (be, wdata_rep, rdata_ext, misaligned).
//  - Top: FSM, request registers, timeout counter, load-data register.
// TESTING
//  - sw addr 0x10 data 0xDEADBEEF, ack at T+1 -> be 1111, bus_addr 0x10, stall 2 cycles (T, T+1), no wb_valid.
//  - lb addr 0x13 with rdata 0x80FF_0000, ack after 3 wait cycles -> be 1000, wb_rdata 0xFFFF_FF80; lbu -> 0x0000_0080.
//  - sh addr 0x06 data 0x1234 -> be 1100, bus_wdata 0x1234_1234; lhu addr 0x06 rdata 0xBEEF_0000 -> 0x0000_BEEF.
//  - lw addr 0x02 -> addr_err pulse, bus_req stays 0, stall 0; lh addr 0x01 likewise; sb at any addr is legal.
//  - TIMEOUT=4, never ack -> bus_req high 4 cycles, then bus_err 1 cycle, wb_valid 0, FSM back in IDLE.
//  - rst asserted during REQ -> next edge all outputs 0; a fresh lw right after completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings and LSU state type shared by the load/store unit
package mem_pkg;
  localparam logic [1:0] MEM_SEL_NONE = 2'b00;
  localparam logic [1:0] MEM_SEL_BYTE = 2'b01;
  localparam logic [1:0] MEM_SEL_HALF = 2'b10;
  localparam logic [1:0] MEM_SEL_WORD = 2'b11;
  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian byte-lane steering for stores and extraction/extension for loads
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  sel_i,
  input  logic [1:0]  a_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o,
  output logic        misaligned_o
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata_i >> {a_i, 3'b000};
    be_o = sel_i == MEM_SEL_BYTE ? 4'b0001 << a_i :
           sel_i == MEM_SEL_HALF ? 4'b0011 << a_i :
           sel_i == MEM_SEL_WORD ? 4'b1111 : 4'b0000;
    wdata_rep_o = sel_i == MEM_SEL_BYTE ? {4{wdata_i[7:0]}} :
                  sel_i == MEM_SEL_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_ext_o = sel_i == MEM_SEL_BYTE ? {{24{~uns_i & sh[7]}}, sh[7:0]} :
                  sel_i == MEM_SEL_HALF ? {{16{~uns_i & sh[15]}}, sh[15:0]} : sh;
    misaligned_o = (sel_i == MEM_SEL_HALF && a_i[0]) || (sel_i == MEM_SEL_WORD && a_i != 2'b00);
  end
endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: single-outstanding load/store initiator with byte enables, timeout abort and WB return
module lsu_bus_master
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_sel,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  lsu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, we_q, uns_q;
  logic [1:0]    sel_q, a_q;
  logic [31:0]   addr_q, wdata_q, rdata_q, rdata_d;
  logic [3:0]    be_q;
  logic          idle, sized, accept, timeout;
  logic [1:0]    sel_m, a_m;
  logic          uns_m, mis_c;
  logic [3:0]    be_c;
  logic [31:0]   wrep_c, rext_c;
  // One aligner serves both phases: request fields from EX while idle, captured fields while busy
  assign idle  = state_q == IDLE;
  assign sel_m = idle ? ex_mem_sel : sel_q;
  assign a_m   = idle ? ex_addr[1:0] : a_q;
  assign uns_m = idle ? ex_unsigned : uns_q;
  lsu_lane_align u_align (
    .sel_i        (sel_m),
    .a_i          (a_m),
    .uns_i        (uns_m),
    .wdata_i      (ex_wdata),
    .rdata_i      (bus_rdata),
    .be_o         (be_c),
    .wdata_rep_o  (wrep_c),
    .rdata_ext_o  (rext_c),
    .misaligned_o (mis_c)
  );
  assign sized     = idle && ex_valid && ex_mem_sel != MEM_SEL_NONE;
  assign accept    = sized && (ex_mem_read ^ ex_mem_write) && !mis_c;
  assign addr_err  = sized && ((ex_mem_read && ex_mem_write) || ((ex_mem_read || ex_mem_write) && mis_c));
  assign timeout   = cnt_q == CW'(TIMEOUT - 1);
  assign stall     = accept || state_q == REQ;
  assign bus_req   = state_q == REQ;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign wb_valid  = state_q == DONE && !we_q && !err_q;
  assign bus_err   = state_q == DONE && err_q;
  assign wb_rdata  = rdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = REQ;
        err_d   = 1'b0;
      end
      REQ: if (bus_ack) begin
        state_d = DONE;
        rdata_d = we_q ? rdata_q : rext_c;
      end else if (timeout) begin
        state_d = DONE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      sel_q   <= MEM_SEL_NONE;
      a_q     <= 2'b00;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= ex_mem_write;
        uns_q   <= ex_unsigned;
        sel_q   <= ex_mem_sel;
        a_q     <= ex_addr[1:0];
        addr_q  <= {ex_addr[31:2], 2'b00};
        be_q    <= be_c;
        wdata_q <= wrep_c;
      end
    end
  end
endmodule
